amm_rd_master: RTL
==================

AMM_RD_MASTER -- requirements
Module: amm_rd_master

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 64, meaning the readdata and stream width in bits.
REQ-002 The block SHALL take parameter ADDR_WIDTH, default 10, meaning the word address width.
REQ-003 The block SHALL take parameter LEN_WIDTH, default 11, meaning the transfer length field width in words.
REQ-004 The block SHALL take parameter MAX_OUTSTANDING, default 8, meaning the read credit limit, a power of 2 and at least 2.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port srst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port start_i, input, 1 bit: a one-cycle request to begin a transfer.
REQ-008 The block SHALL have port base_addr_i, input, ADDR_WIDTH bits: the first word address, sampled when start_i is accepted.
REQ-009 The block SHALL have port length_i, input, LEN_WIDTH bits: the word count, sampled when start_i is accepted.
REQ-010 The block SHALL have port busy_o, output, 1 bit: high from start accept until done_o.
REQ-011 The block SHALL have port done_o, output, 1 bit: a one-cycle pulse when the transfer is complete.
REQ-012 The block SHALL have port amm_rd_address_o, output, ADDR_WIDTH bits: the Avalon-MM read address.
REQ-013 The block SHALL have port amm_rd_read_o, output, 1 bit: the Avalon-MM read request.
REQ-014 The block SHALL have port amm_rd_waitrequest_i, input, 1 bit: slave stall.
REQ-015 The block SHALL have port amm_rd_readdata_i, input, DATA_WIDTH bits: the read data.
REQ-016 The block SHALL have port amm_rd_readdatavalid_i, input, 1 bit: read data qualifier.
REQ-017 The block SHALL have port data_o, output, DATA_WIDTH bits: stream data, in address order.
REQ-018 The block SHALL have port valid_o, output, 1 bit: stream data valid.
REQ-019 The block SHALL have port ready_i, input, 1 bit: stream sink ready.

Function
REQ-020 The state machine SHALL have the states IDLE, ISSUE, DRAIN and DONE.
REQ-021 In IDLE, a start_i with length_i>0 SHALL latch the address and length and move to ISSUE on the next cycle; start_i with length_i==0 SHALL move directly to DONE.
REQ-022 start_i outside IDLE SHALL be ignored.
REQ-023 In ISSUE, amm_rd_read_o SHALL be asserted only while the count of issued-but-unreturned reads plus the FIFO occupancy is less than MAX_OUTSTANDING.
REQ-024 A read SHALL be accepted on a cycle with amm_rd_read_o=1 and amm_rd_waitrequest_i=0; the address then increments by 1 and wraps modulo 2^ADDR_WIDTH.
REQ-025 While amm_rd_waitrequest_i=1, amm_rd_read_o and amm_rd_address_o SHALL hold stable; read SHALL NOT be deasserted before acceptance.
REQ-026 After length_i reads are accepted, amm_rd_read_o SHALL go low in the following cycle and the FSM SHALL enter DRAIN.
REQ-027 Each amm_rd_readdatavalid_i=1 SHALL write amm_rd_readdata_i into an internal FIFO of depth MAX_OUTSTANDING and decrement the outstanding count.
REQ-028 The credit rule SHALL make FIFO overflow impossible.
REQ-029 readdatavalid with zero outstanding reads is a slave protocol error; the data SHALL be dropped and the outstanding count SHALL NOT underflow.
REQ-030 FIFO head SHALL drive data_o and valid_o=!empty; a pop SHALL occur on valid_o & ready_i.
REQ-031 data_o SHALL be stable while valid_o=1 and ready_i=0.
REQ-032 Simultaneous accept, return and pop SHALL update both counters correctly in the same cycle, with no credit lost or double-counted.
REQ-033 Read latency SHALL NOT be assumed: a return may arrive one or more cycles after accept, including in the same cycle as a later accept.
REQ-034 DRAIN SHALL move to DONE when the outstanding count is 0, the FIFO is empty, and all length_i words have been popped.
REQ-035 DONE SHALL assert done_o for exactly one cycle and return to IDLE; busy_o SHALL be 0 in IDLE and DONE and 1 otherwise.
REQ-036 Throughput SHALL be 1 word per cycle sustained when waitrequest=0 and ready_i=1.
REQ-037 The first amm_rd_read_o SHALL assert 1 cycle after start_i.

Reset
REQ-038 srst_i SHALL force state IDLE and set amm_rd_read_o=0, amm_rd_address_o=0, busy_o=0, done_o=0, valid_o=0, data_o=0, clear the FIFO and set the counters to 0.
REQ-039 srst_i mid-transfer SHALL abort immediately with no done_o.
REQ-040 Read returns arriving after reset SHALL be discarded per REQ-029.
REQ-041 Reset SHALL have priority over start_i in the same cycle.

Verification
REQ-042 base=0x010, len=4, waitrequest=0, latency 1, ready=1: reads at 0x010..0x013 on consecutive cycles; data_o in order; done_o once; 4 stream beats.
REQ-043 len=20, latency 64, ready=1: never more than 8 outstanding; read deasserts at the credit limit; all 20 words in order; done_o once.
REQ-044 Random waitrequest 50%, random latency 1..64, ready random 50%, len=100: address and read stable under waitrequest; no FIFO overflow; the sequence matches the memory image.
REQ-045 base=0x3FE, len=4, ADDR_WIDTH=10: addresses 0x3FE, 0x3FF, 0x000, 0x001.
REQ-046 len=0: no amm_rd_read_o; done_o 1 cycle after start_i; busy_o stays 0.
REQ-047 srst_i asserted with 3 reads outstanding, then a new start base=0x100, len=2: stale returns are dropped; exactly 2 beats from 0x100/0x101 are output; done_o once.

Source files
------------

// File: rtl/amm_rd_master.sv
// Avalon-MM burstless read master: streams length_i words starting at base_addr_i
// out of a credit-limited reorder-free FIFO, in address order.
module amm_rd_master #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned ADDR_WIDTH      = 10,
  parameter int unsigned LEN_WIDTH       = 11,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]  length_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] amm_rd_address_o,
  output logic                  amm_rd_read_o,
  input  logic                  amm_rd_waitrequest_i,
  input  logic [DATA_WIDTH-1:0] amm_rd_readdata_i,
  input  logic                  amm_rd_readdatavalid_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                state;
  logic [LEN_WIDTH-1:0]  issue_left;
  logic [LEN_WIDTH-1:0]  pop_left;
  logic [CNT_W-1:0]      outstanding;
  logic [CNT_W-1:0]      fcnt;
  logic [CNT_W-1:0]      out_nxt;
  logic [CNT_W-1:0]      fcnt_after_pop;
  logic [CNT_W-1:0]      fcnt_nxt;
  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;
  logic [PTR_W-1:0]      rptr_nxt;
  logic [DATA_WIDTH-1:0] mem [MAX_OUTSTANDING];
  logic [DATA_WIDTH-1:0] head_nxt;
  logic                  accept;
  logic                  ret;
  logic                  pop;
  logic                  credit_ok;

  // Next-cycle counter/FIFO view; credits count both in-flight reads and buffered words.
  always_comb begin
    accept         = amm_rd_read_o & ~amm_rd_waitrequest_i;
    ret            = amm_rd_readdatavalid_i & (outstanding != '0);
    pop            = valid_o & ready_i;
    out_nxt        = outstanding + CNT_W'(accept) - CNT_W'(ret);
    fcnt_after_pop = fcnt - CNT_W'(pop);
    fcnt_nxt       = fcnt_after_pop + CNT_W'(ret);
    rptr_nxt       = rptr + PTR_W'(pop);
    credit_ok      = (SUM_W'(out_nxt) + SUM_W'(fcnt_nxt)) < SUM_W'(MAX_OUTSTANDING);
    head_nxt       = (fcnt_after_pop == '0) ? amm_rd_readdata_i : mem[rptr_nxt];
  end

  // FIFO storage; returns with no outstanding read never reach it.
  always_ff @(posedge clk_i) begin
    if (ret) mem[wptr] <= amm_rd_readdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state            <= IDLE;
      issue_left       <= '0;
      pop_left         <= '0;
      outstanding      <= '0;
      fcnt             <= '0;
      wptr             <= '0;
      rptr             <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      amm_rd_address_o <= '0;
      amm_rd_read_o    <= 1'b0;
      data_o           <= '0;
      valid_o          <= 1'b0;
    end else begin
      outstanding <= out_nxt;
      fcnt        <= fcnt_nxt;
      wptr        <= wptr + PTR_W'(ret);
      rptr        <= rptr_nxt;
      valid_o     <= (fcnt_nxt != '0);
      if (fcnt_nxt != '0) data_o <= head_nxt;
      if (pop && pop_left != '0) pop_left <= pop_left - LEN_WIDTH'(1);
      if (accept) amm_rd_address_o <= amm_rd_address_o + ADDR_WIDTH'(1);
      done_o <= 1'b0;

      case (state)
        IDLE: begin
          if (start_i) begin
            if (length_i != '0) begin
              state            <= ISSUE;
              busy_o           <= 1'b1;
              amm_rd_address_o <= base_addr_i;
              issue_left       <= length_i;
              pop_left         <= length_i;
              amm_rd_read_o    <= 1'b1;
            end else begin
              state  <= DONE;
              done_o <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (accept) issue_left <= issue_left - LEN_WIDTH'(1);
          if (accept && issue_left == LEN_WIDTH'(1)) begin
            amm_rd_read_o <= 1'b0;
            state         <= DRAIN;
          end else if (!(amm_rd_read_o && amm_rd_waitrequest_i)) begin
            amm_rd_read_o <= credit_ok;
          end
        end
        DRAIN: begin
          if (outstanding == '0 && fcnt == '0 && pop_left == '0) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
